i2s_transmitter: RTL and testbench
==================================

# i2s_transmitter

Converts the tagged sample stream from `stereo_audio_serializer` into a standard I2S bit stream (`o_bclk`, `o_lrclk`, `o_sdata`). It sits at the output end of the audio chain. It collects one left and one right 32-bit word into a pending frame, then shifts that frame out MSB-first. It is double-buffered, so the next frame can be accepted while the current one is transmitted.

## Interface
- `CLK_DIV`, default 1: `clk` cycles per BCLK half-period; legal values ≥ 1. BCLK period is 2·CLK_DIV clocks.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  reset; asynchronous and active-low.
- `i_valid`  in  1  input sample valid.
- `i_ready`  out  1  block can accept a sample.
- `i_is_left`  in  1  1 = left sample, 0 = right sample.
- `i_audio`  in  32  sample, two's complement.
- `o_bclk`  out  1  I2S bit clock.
- `o_lrclk`  out  1  I2S word select; 0 = left slot, 1 = right slot.
- `o_sdata`  out  1  I2S serial data.
- `o_underrun`  out  1  one-clk pulse when a frame boundary finds no complete pending frame.
- `o_seq_error`  out  1  one-clk pulse when an input sample is out of order.

## Operation
- **Pending frame:** registers `pend_l`, `pend_r`, and flags `have_l`, `have_r`.
  - `i_ready = !(have_l && have_r)`.
  - Handshake occurs when `i_valid && i_ready`.
- **Accepted left:** `pend_l <= i_audio`, `have_l <= 1`.
  - If `have_l` was already set and `have_r` is clear, the left word is overwritten and `o_seq_error` pulses.
- **Accepted right:**
  - With `have_l` set: `pend_r <= i_audio`, `have_r <= 1`.
  - With `have_l` clear: the sample is consumed and discarded, and `o_seq_error` pulses.
- **Divider:** `div_cnt` counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps and `o_bclk` toggles.
  - A "falling event" is a toggle that takes `o_bclk` from 1 to 0.
- **Bit counter:** `bit_cnt` covers 0..63 and advances by 1 (mod 64) on each falling event.
  - Bits 0–31 are the left slot; bits 32–63 are the right slot.
- **Frame load:** happens on the falling event where `bit_cnt` wraps 63→0.
  - If the pending frame is complete, the 64-bit shift frame is loaded with `{pend_l, pend_r}`, and `have_l`/`have_r` are cleared in the same cycle.
  - Otherwise the shift frame is loaded with 0, `o_underrun` pulses, and the pending contents and flags are kept.
- **Simultaneous handshake and load:** a load can only coincide with a handshake when the pending frame is incomplete, because `i_ready` is 0 when it is full. The result is an underrun, and the newly accepted sample is retained in pending.
- **Serial data:** `o_sdata` is the frame bit for the current `bit_cnt`: `frame[63-bit_cnt]`. This sends the left MSB first, then the right MSB.
- **Word select:** `o_lrclk` = 1 for `bit_cnt` 31..62, else 0. It therefore changes one BCLK before each slot's MSB (I2S one-bit delay).
- **Output changes:** `o_sdata` and `o_lrclk` change only on falling events and are registered. The receiver samples them on rising BCLK.

## Timing
- **Reset values:**
  - Outputs: `o_bclk`=0, `o_lrclk`=0, `o_sdata`=0, `i_ready`=1, `o_underrun`=0, `o_seq_error`=0.
  - Internal state: `div_cnt`=0, `bit_cnt`=63, frame=0, `have_l`/`have_r`=0.
- **After reset release:**
  - The first rising BCLK is at clk edge CLK_DIV.
  - The first falling event is at edge 2·CLK_DIV. This is the first frame load; left MSB is on `o_sdata`.
- **Frame length:** exactly 128·CLK_DIV clocks; loads occur at edges 2·CLK_DIV + k·128·CLK_DIV.
- **Input latency:** a frame completed at least one clk before a load edge is transmitted from that load. Completion on the load edge itself counts as underrun.
- **Reset mid-frame:** reasserting `reset_n` immediately returns every register to its reset value and drops pending samples. No partial frame resumes.
- **Pulse rule:** `o_underrun` and `o_seq_error` are registered pulses, high for exactly one clk per event.

## Test plan
- **Reset:** hold `reset_n`=0 with `i_valid`=1 → all outputs at reset values. After release with no input, `o_bclk` toggles every CLK_DIV clocks and `o_sdata` stays 0.
- **Single frame, CLK_DIV=1:** L=32'h80000001, R=32'h12345678 delivered before edge 2.
  - `o_sdata` over bits 0–31 is 1, 0×30, 1.
  - Bits 32–63 give 0x12345678 MSB-first.
  - `o_lrclk` is high for bits 31–62.
- **Underrun:** no input → `o_underrun` pulses at edges 2, 130, 258…; `o_sdata` stays 0. Supplying L=0x55555555 alone still underruns, and the left word is retained for the next frame.
- **Backpressure:** three frames offered back-to-back (0x11111111/0x22222222, 0x33333333/0x44444444, 0x55555555/0x66666666).
  - `i_ready` drops after each right word and rises on the load edge.
  - All frames are transmitted in order with no underrun.
- **Sequence error:**
  - R=0xDEADBEEF sent first → discarded, with an `o_seq_error` pulse.
  - L=0x1, L=0x2, R=0x3 → one error pulse; the transmitted frame is 0x2/0x3.
- **Reset mid-frame:** assert `reset_n` at `bit_cnt`=40 → outputs are at reset values the same cycle. After release, the pending samples are gone and the first frame underruns.

Source files
------------

// File: rtl/i2s_transmitter.sv
// I2S transmitter: gathers one left and one right 32-bit sample into a
// pending frame, then shifts the 64-bit frame out MSB-first on an I2S bus
// (BCLK, LRCLK, SDATA). The pending frame and the shift frame form a double
// buffer, so the next frame can be collected while the current one is sent.
module i2s_transmitter #(
  parameter int CLK_DIV = 1  // clk cycles per BCLK half-period, >= 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic        i_is_left,
  input  logic [31:0] i_audio,
  output logic        o_bclk,
  output logic        o_lrclk,
  output logic        o_sdata,
  output logic        o_underrun,
  output logic        o_seq_error
);

  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0]        BIT_LAST = 6'd63;

  // BCLK generation
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;

  // Serial side: slot position, shift frame and registered bus outputs
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic [63:0]      shift_q, shift_d;
  logic             sdata_q, sdata_d;
  logic             lrclk_q, lrclk_d;
  logic             underrun_q, underrun_d;

  // Input side: pending frame being assembled
  logic [31:0]      pend_l_q, pend_l_d;
  logic [31:0]      pend_r_q, pend_r_d;
  logic             have_l_q, have_l_d;
  logic             have_r_q, have_r_d;
  logic             seq_err_q, seq_err_d;

  // Event decode
  logic             div_wrap;
  logic             fall_evt;
  logic             frame_edge;
  logic             frame_full;
  logic             accept;
  logic [63:0]      next_frame;

  assign div_wrap   = (div_cnt_q == DIV_LAST);
  // BCLK is high and about to toggle: this is the falling edge of BCLK.
  assign fall_evt   = div_wrap && bclk_q;
  assign frame_edge = fall_evt && (bit_cnt_q == BIT_LAST);
  assign frame_full = have_l_q && have_r_q;
  assign accept     = i_valid && i_ready;

  // Divider: count clk cycles and toggle BCLK every CLK_DIV clocks
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    div_cnt_d = div_cnt_q + DIV_W'(1);
    bclk_d    = bclk_q;
    if (div_wrap) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end
  end

  // Serial side: advance the slot on each falling BCLK, load a new frame at
  // the 63->0 wrap, and present the next bit and word select
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sdata_d    = sdata_q;
    lrclk_d    = lrclk_q;
    underrun_d = 1'b0;
    next_frame = shift_q;

    if (fall_evt) begin
      bit_cnt_d = bit_cnt_q + 6'd1;
      // Word select leads the slot's MSB by one bit (I2S one-bit delay).
      lrclk_d   = (bit_cnt_d >= 6'd31) && (bit_cnt_d <= 6'd62);

      if (frame_edge) begin
        if (frame_full) begin
          next_frame = {pend_l_q, pend_r_q};
        end else begin
          // Nothing complete to send: transmit silence, keep what is pending.
          next_frame = '0;
          underrun_d = 1'b1;
        end
      end

      // The shift register holds the bits still to come after the one on SDATA.
      sdata_d = next_frame[63];
      shift_d = {next_frame[62:0], 1'b0};
    end
  end

  // Input side: accept samples in L,R order and flag anything out of order
  always_comb begin
    pend_l_d  = pend_l_q;
    pend_r_d  = pend_r_q;
    have_l_d  = have_l_q;
    have_r_d  = have_r_q;
    seq_err_d = 1'b0;

    // A full frame hands over to the shift register; i_ready is low while
    // full, so this never coincides with an accepted sample.
    if (frame_edge && frame_full) begin
      have_l_d = 1'b0;
      have_r_d = 1'b0;
    end

    if (accept) begin
      if (i_is_left) begin
        // A second left before its right replaces the earlier one.
        if (have_l_q && !have_r_q) begin
          seq_err_d = 1'b1;
        end
        pend_l_d = i_audio;
        have_l_d = 1'b1;
      end else if (have_l_q) begin
        pend_r_d = i_audio;
        have_r_d = 1'b1;
      end else begin
        // Right without a preceding left: consume and drop it.
        seq_err_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      bit_cnt_q  <= BIT_LAST;
      shift_q    <= '0;
      sdata_q    <= 1'b0;
      lrclk_q    <= 1'b0;
      underrun_q <= 1'b0;
      // NOTE: the sample registers are reset too, although the have_* flags alone already mark them empty; it keeps the datapath free of X after reset.
      pend_l_q   <= '0;
      pend_r_q   <= '0;
      have_l_q   <= 1'b0;
      have_r_q   <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the pre-edge state, independent of statement order.
      div_cnt_q  <= div_cnt_d;
      bclk_q     <= bclk_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      sdata_q    <= sdata_d;
      lrclk_q    <= lrclk_d;
      underrun_q <= underrun_d;
      pend_l_q   <= pend_l_d;
      pend_r_q   <= pend_r_d;
      have_l_q   <= have_l_d;
      have_r_q   <= have_r_d;
      seq_err_q  <= seq_err_d;
    end
  end

  assign i_ready     = !(have_l_q && have_r_q);
  assign o_bclk      = bclk_q;
  assign o_lrclk     = lrclk_q;
  assign o_sdata     = sdata_q;
  assign o_underrun  = underrun_q;
  assign o_seq_error = seq_err_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter. A reference model derives every expected output
// from the clk edge count since reset release plus a transaction-level copy
// of the pending frame; all six outputs are compared after every clk edge.
module tb_i2s_transmitter;

  localparam int DIV        = 2;
  localparam int FRAME_CLKS = 128 * DIV;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        valid = 1'b0;
  logic        is_left = 1'b0;
  logic [31:0] audio = '0;
  logic        i_ready, o_bclk, o_lrclk, o_sdata, o_underrun, o_seq_error;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state
  int          n = 0;        // clk edges since reset release
  logic [31:0] m_l, m_r;
  bit          m_hl, m_hr;
  logic [63:0] cur_frame;    // frame currently on the wire
  bit          exp_under, exp_seq;
  bit          last_hs;

  i2s_transmitter #(.CLK_DIV(DIV)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_valid     (valid),
    .i_ready     (i_ready),
    .i_is_left   (is_left),
    .i_audio     (audio),
    .o_bclk      (o_bclk),
    .o_lrclk     (o_lrclk),
    .o_sdata     (o_sdata),
    .o_underrun  (o_underrun),
    .o_seq_error (o_seq_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed=%b expected=%b", tag, n, obs, exp_v);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bclk"},  o_bclk,      1'b0);
    check({tag, "_lrclk"}, o_lrclk,     1'b0);
    check({tag, "_sdata"}, o_sdata,     1'b0);
    check({tag, "_ready"}, i_ready,     1'b1);
    check({tag, "_under"}, o_underrun,  1'b0);
    check({tag, "_seq"},   o_seq_error, 1'b0);
  endtask

  // Assert reset (with a valid sample offered), check reset values at once
  // and again after two clks, release at a falling clk edge.
  task automatic do_reset();
    reset_n = 1'b0;
    valid   = 1'b1;
    is_left = 1'b1;
    audio   = $urandom;
    #1;
    check_reset_values("rst_now");
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst_hold");
    @(negedge clk);
    reset_n   = 1'b1;
    valid     = 1'b0;
    n         = 0;
    m_l       = '0;
    m_r       = '0;
    m_hl      = 1'b0;
    m_hr      = 1'b0;
    cur_frame = '0;
  endtask

  // One clk edge: update the model from the rules, then compare all outputs.
  task automatic tick();
    bit full, hs, load;
    int f, bit_i;
    logic exp_sdata;
    @(posedge clk);
    n++;
    full      = m_hl && m_hr;
    hs        = valid && !full;
    last_hs   = hs;
    exp_under = 1'b0;
    exp_seq   = 1'b0;
    load      = (n % FRAME_CLKS) == 2 * DIV;
    if (load) begin
      if (full) begin
        cur_frame = {m_l, m_r};
        m_hl = 1'b0;
        m_hr = 1'b0;
      end else begin
        cur_frame = '0;
        exp_under = 1'b1;
      end
    end
    if (hs) begin
      if (is_left) begin
        if (m_hl && !m_hr) exp_seq = 1'b1;
        m_l  = audio;
        m_hl = 1'b1;
      end else if (m_hl) begin
        m_r  = audio;
        m_hr = 1'b1;
      end else begin
        exp_seq = 1'b1;
      end
    end
    #1;
    f         = n / (2 * DIV);
    bit_i     = (f == 0) ? 63 : (f - 1) % 64;
    exp_sdata = (f == 0) ? 1'b0 : cur_frame[63 - bit_i];
    check("bclk",      o_bclk,      ((n / DIV) % 2) == 1);
    check("lrclk",     o_lrclk,     (bit_i >= 31) && (bit_i <= 62));
    check("sdata",     o_sdata,     exp_sdata);
    check("ready",     i_ready,     !(m_hl && m_hr));
    check("underrun",  o_underrun,  exp_under);
    check("seq_error", o_seq_error, exp_seq);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  // Offer one sample and hold it until the handshake (bounded by two frames).
  task automatic send(input bit left, input logic [31:0] data);
    int waited;
    waited  = 0;
    valid   = 1'b1;
    is_left = left;
    audio   = data;
    do begin
      tick();
      waited++;
    end while (!last_hs && waited < 2 * FRAME_CLKS);
    valid = 1'b0;
  endtask

  // Advance until the edge just before the next frame load.
  task automatic run_to_pre_load();
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      if ((n + 1) % FRAME_CLKS == 2 * DIV) break;
      tick();
    end
  endtask

  initial begin
    #2;
    // Reset with valid asserted, then idle: BCLK runs, SDATA silent, underruns.
    do_reset();
    idle(2 * FRAME_CLKS + 4 * DIV);

    // Single frame delivered before the first load.
    do_reset();
    send(1'b1, 32'h8000_0001);
    send(1'b0, 32'h1234_5678);
    idle(FRAME_CLKS + 4 * DIV);

    // Left alone still underruns and is kept; the right completes it later.
    do_reset();
    send(1'b1, 32'h5555_5555);
    idle(FRAME_CLKS);
    send(1'b0, 32'hAAAA_0F0F);
    idle(FRAME_CLKS + 4 * DIV);

    // Right completing exactly on a load edge: underrun, frame goes next time.
    send(1'b1, 32'hC0DE_0001);
    run_to_pre_load();
    send(1'b0, 32'hC0DE_0002);
    idle(FRAME_CLKS + 4 * DIV);

    // Backpressure: three frames back to back.
    send(1'b1, 32'h1111_1111);
    send(1'b0, 32'h2222_2222);
    send(1'b1, 32'h3333_3333);
    send(1'b0, 32'h4444_4444);
    send(1'b1, 32'h5555_5555);
    send(1'b0, 32'h6666_6666);
    idle(2 * FRAME_CLKS);

    // Sequence errors: orphan right, then a doubled left.
    send(1'b0, 32'hDEAD_BEEF);
    send(1'b1, 32'h0000_0001);
    send(1'b1, 32'h0000_0002);
    send(1'b0, 32'h0000_0003);
    idle(FRAME_CLKS + 4 * DIV);

    // Reset mid-frame at bit 40 with a full frame pending.
    send(1'b1, 32'hF00D_0001);
    send(1'b0, 32'hF00D_0002);
    send(1'b1, 32'hF00D_0003);
    send(1'b0, 32'hF00D_0004);
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      if (n >= 2 * DIV && n % (2 * DIV) == 0 && ((n / (2 * DIV)) - 1) % 64 == 40) break;
      tick();
    end
    do_reset();
    idle(FRAME_CLKS + 4 * DIV);

    // Randomized traffic: mostly in-order samples, occasional disorder and gaps.
    for (int k = 0; k < 200; k++) begin
      int r;
      bit left;
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        idle(int'($urandom_range(0, 40)));
      end else begin
        left = !m_hl || m_hr;
        if (r == 9) left = !left;
        send(left, $urandom);
      end
    end
    idle(2 * FRAME_CLKS);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
